// File: rtl/snail_scan_ctrl_pkg.sv
// snail_scan_pkg: shared state encoding and configuration limits for the
// snail scan sequencer (snail_scan_ctrl) and its bit-period divider.
package snail_scan_pkg;

    typedef enum bit [1:0] {
        SCAN_IDLE  = 2'd0,
        SCAN_LOAD  = 2'd1,
        SCAN_SHIFT = 2'd2,
        SCAN_DONE  = 2'd3
    } scan_state_e;

    // Smallest legal word width and bit period
    localparam int unsigned SCAN_W_MIN   = 32'd2;
    localparam int unsigned SCAN_DIV_MIN = 32'd1;

endpackage

// File: rtl/snail_scan_ctrl_if.sv
// snail_scan_ctrl_if: control-side bus of the snail scan sequencer
// (start/word in, busy/done/match_cnt out).
// Optional macro SNAIL_SCAN_FIRST_POS_EN adds first_vld/first_pos.
interface snail_scan_ctrl_if #(
    parameter int unsigned W     = 8,
    parameter int unsigned CNT_W = 4
);
    logic             start;
    logic [W-1:0]     word;
    logic             busy;
    logic             done;
    logic [CNT_W-1:0] match_cnt;
`ifdef SNAIL_SCAN_FIRST_POS_EN
    logic                 first_vld;
    logic [$clog2(W)-1:0] first_pos;
`endif

    modport master (
        output start, word,
        input  busy, done, match_cnt
`ifdef SNAIL_SCAN_FIRST_POS_EN
        , input first_vld, first_pos
`endif
    );

    modport slave (
        input  start, word,
        output busy, done, match_cnt
`ifdef SNAIL_SCAN_FIRST_POS_EN
        , output first_vld, first_pos
`endif
    );
endinterface

// File: rtl/snail_scan_ctrl_strobe.sv
// snail_scan_strobe: bit-period divider. Counts 0..DIV-1 while running and
// flags the last count of each period; o_strobe_nxt predicts the flag one
// cycle ahead so the parent can register its en output.
module snail_scan_strobe #(
    parameter int unsigned DIV = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic i_clr,
    input  logic i_run,
    output logic o_strobe,
    output logic o_strobe_nxt
);
    localparam int unsigned   CW   = (DIV > 32'd1) ? $clog2(DIV) : 32'd1;
    localparam logic [CW-1:0] LAST = CW'(DIV - 32'd1);

    logic [CW-1:0] r_cnt;
    logic [CW-1:0] w_cnt_nxt;
    logic          w_last;

    assign w_last       = (r_cnt == LAST);
    assign o_strobe     = i_run & w_last;
    assign o_strobe_nxt = (w_cnt_nxt == LAST);

    // Next count: cleared on clr, wraps after the strobe, holds when not running
    always_comb begin
        w_cnt_nxt = r_cnt;
        if (i_clr) begin
            w_cnt_nxt = {CW{1'b0}};
        end else if (i_run) begin
            if (w_last) begin
                w_cnt_nxt = {CW{1'b0}};
            end else begin
                w_cnt_nxt = r_cnt + CW'(1);
            end
        end else begin
            w_cnt_nxt = r_cnt;
        end
    end

    // Divider count register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt <= {CW{1'b0}};
        end else begin
            r_cnt <= w_cnt_nxt;
        end
    end
endmodule

// File: rtl/snail_scan_ctrl.sv
// snail_scan_ctrl: loads a word, streams it LSB-first into the snail Mealy
// detector one bit per DIV clocks (en strobe per bit), counts y hits and
// pulses done. All outputs are flops loaded from next-state values.
// Optional macro SNAIL_SCAN_FIRST_POS_EN records the bit index of the first hit.
module snail_scan_ctrl
    import snail_scan_pkg::*;
#(
    parameter int unsigned W     = 8,
    parameter int unsigned DIV   = 4,
    parameter int unsigned CNT_W = 4
) (
    input  logic               clk,
    input  logic               rst,
    snail_scan_ctrl_if.slave   bus,
    input  logic               i_y_in,
    output logic               o_a_out,
    output logic               o_en_out,
    output logic               o_det_rst
);
    localparam int unsigned IW      = (W < SCAN_W_MIN) ? 32'd1 : $clog2(W);
    localparam int unsigned DIV_EFF = (DIV < SCAN_DIV_MIN) ? SCAN_DIV_MIN : DIV;

    localparam logic [1:0] ST_IDLE  = SCAN_IDLE;
    localparam logic [1:0] ST_LOAD  = SCAN_LOAD;
    localparam logic [1:0] ST_SHIFT = SCAN_SHIFT;
    localparam logic [1:0] ST_DONE  = SCAN_DONE;

    localparam logic [IW-1:0]    LAST_IDX = IW'(W - 32'd1);
    localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};

    logic [1:0]       r_state,     w_state_nxt;
    logic [W-1:0]     r_shreg,     w_shreg_nxt;
    logic [IW-1:0]    r_bit_idx,   w_bit_idx_nxt;
    logic [CNT_W-1:0] r_match_cnt, w_match_cnt_nxt;
    logic             r_a_out, r_en_out, r_det_rst, r_busy, r_done;
    logic             w_strobe, w_strobe_nxt;
`ifdef SNAIL_SCAN_FIRST_POS_EN
    logic             r_first_vld, w_first_vld_nxt;
    logic [IW-1:0]    r_first_pos, w_first_pos_nxt;
`endif

    snail_scan_strobe #(.DIV(DIV_EFF)) u_strobe (
        .clk          (clk),
        .rst          (rst),
        .i_clr        (r_state == ST_LOAD),
        .i_run        (r_state == ST_SHIFT),
        .o_strobe     (w_strobe),
        .o_strobe_nxt (w_strobe_nxt)
    );

    // Sequencer next-state: capture on start, shift and count on each strobe
    always_comb begin
        w_state_nxt     = r_state;
        w_shreg_nxt     = r_shreg;
        w_bit_idx_nxt   = r_bit_idx;
        w_match_cnt_nxt = r_match_cnt;
`ifdef SNAIL_SCAN_FIRST_POS_EN
        w_first_vld_nxt = r_first_vld;
        w_first_pos_nxt = r_first_pos;
`endif
        case (r_state)
            ST_IDLE: begin
                if (bus.start) begin
                    w_state_nxt     = ST_LOAD;
                    w_shreg_nxt     = bus.word;
                    w_bit_idx_nxt   = {IW{1'b0}};
                    w_match_cnt_nxt = {CNT_W{1'b0}};
`ifdef SNAIL_SCAN_FIRST_POS_EN
                    w_first_vld_nxt = 1'b0;
                    w_first_pos_nxt = {IW{1'b0}};
`endif
                end else begin
                    w_state_nxt = ST_IDLE;
                end
            end
            ST_LOAD: begin
                w_state_nxt = ST_SHIFT;
            end
            ST_SHIFT: begin
                if (w_strobe) begin
                    // y is only meaningful while en is asserted
                    if (i_y_in) begin
                        if (r_match_cnt != CNT_MAX) begin
                            w_match_cnt_nxt = r_match_cnt + CNT_W'(1);
                        end else begin
                            w_match_cnt_nxt = r_match_cnt;
                        end
`ifdef SNAIL_SCAN_FIRST_POS_EN
                        if (!r_first_vld) begin
                            w_first_vld_nxt = 1'b1;
                            w_first_pos_nxt = r_bit_idx;
                        end else begin
                            w_first_vld_nxt = r_first_vld;
                        end
`endif
                    end else begin
                        w_match_cnt_nxt = r_match_cnt;
                    end
                    w_shreg_nxt   = {1'b0, r_shreg[W-1:1]};
                    w_bit_idx_nxt = r_bit_idx + IW'(1);
                    if (r_bit_idx == LAST_IDX) begin
                        w_state_nxt = ST_DONE;
                    end else begin
                        w_state_nxt = ST_SHIFT;
                    end
                end else begin
                    w_state_nxt = ST_SHIFT;
                end
            end
            ST_DONE: begin
                w_state_nxt = ST_IDLE;
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // Sequencer state, data path and match bookkeeping
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= ST_IDLE;
            r_shreg     <= {W{1'b0}};
            r_bit_idx   <= {IW{1'b0}};
            r_match_cnt <= {CNT_W{1'b0}};
`ifdef SNAIL_SCAN_FIRST_POS_EN
            r_first_vld <= 1'b0;
            r_first_pos <= {IW{1'b0}};
`endif
        end else begin
            r_state     <= w_state_nxt;
            r_shreg     <= w_shreg_nxt;
            r_bit_idx   <= w_bit_idx_nxt;
            r_match_cnt <= w_match_cnt_nxt;
`ifdef SNAIL_SCAN_FIRST_POS_EN
            r_first_vld <= w_first_vld_nxt;
            r_first_pos <= w_first_pos_nxt;
`endif
        end
    end

    // Output flops decoded from the state being entered, so they line up with it
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
            r_det_rst <= 1'b0;
            r_en_out  <= 1'b0;
            r_a_out   <= 1'b0;
        end else begin
            r_busy    <= (w_state_nxt == ST_LOAD) || (w_state_nxt == ST_SHIFT);
            r_done    <= (w_state_nxt == ST_DONE);
            r_det_rst <= (w_state_nxt == ST_LOAD);
            r_en_out  <= (w_state_nxt == ST_SHIFT) && w_strobe_nxt;
            r_a_out   <= (w_state_nxt == ST_SHIFT) ? w_shreg_nxt[0] : 1'b0;
        end
    end

    assign o_a_out       = r_a_out;
    assign o_en_out      = r_en_out;
    assign o_det_rst     = r_det_rst;
    assign bus.busy      = r_busy;
    assign bus.done      = r_done;
    assign bus.match_cnt = r_match_cnt;
`ifdef SNAIL_SCAN_FIRST_POS_EN
    assign bus.first_vld = r_first_vld;
    assign bus.first_pos = r_first_pos;
`endif
endmodule
